// File: rtl/sevenseg_rx_decoder.sv
// rtl/sevenseg_rx_decoder.sv - glitch-filtered decoder for a multiplexed active-low 7-segment bus
// Optional: define HEX_DECODE_EN to accept the A..F glyphs as legal values 10..15.
module sevenseg_rx_decoder #(
  parameter int NUM_DIGITS = 6,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dvalid,
  output logic                    update,
  output logic                    bad_pattern,
  output logic                    sel_err
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [6:0]    BLANK   = 7'h7F;

  logic [6:0]              cand      [NUM_DIGITS];
  logic [CW-1:0]           cnt       [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   committed;

  logic [6:0]              cand_n    [NUM_DIGITS];
  logic [CW-1:0]           cnt_n     [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   comm_n;
  logic [4*NUM_DIGITS-1:0] digits_n;
  logic [NUM_DIGITS-1:0]   dvalid_n;
  logic                    update_n;
  logic                    bad_n;
  logic                    sel_err_n;
  logic                    onehot;
  logic                    commit;
  logic [4:0]              dec;

  // Returns {legal, value}; blank and illegal patterns both return legal=0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
`ifdef HEX_DECODE_EN
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
`endif
      default:    r = 5'd0;
    endcase
    return r;
  endfunction

  assign onehot = $onehot(dig_sel);

  always_comb begin
    cand_n    = cand;
    cnt_n     = cnt;
    comm_n    = committed;
    digits_n  = digits;
    dvalid_n  = dvalid;
    bad_n     = 1'b0;
    sel_err_n = sample_en && !onehot;
    commit    = 1'b0;
    dec       = 5'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sample_en && onehot && dig_sel[i]) begin
        if (seg_in != cand[i]) begin
          cand_n[i] = seg_in;
          cnt_n[i]  = CNT_ONE;
          comm_n[i] = 1'b0;
          commit    = (CNT_ONE == CNT_MAX);
        end else begin
          if (cnt[i] < CNT_MAX) cnt_n[i] = cnt[i] + CNT_ONE;
          commit = (cnt_n[i] == CNT_MAX) && !committed[i];
        end
        // committed blocks a re-commit until the pattern changes again
        if (commit) begin
          comm_n[i] = 1'b1;
          dec       = decode(seg_in);
          if (dec[4]) begin
            digits_n[4*i +: 4] = dec[3:0];
            dvalid_n[i]        = 1'b1;
          end else begin
            dvalid_n[i] = 1'b0;
            bad_n       = (seg_in != BLANK);
          end
        end
      end
    end
    update_n = (digits_n != digits) || (dvalid_n != dvalid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand[i] <= BLANK;
        cnt[i]  <= '0;
      end
      committed   <= '0;
      digits      <= '0;
      dvalid      <= '0;
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      cand        <= cand_n;
      cnt         <= cnt_n;
      committed   <= comm_n;
      digits      <= digits_n;
      dvalid      <= dvalid_n;
      update      <= update_n;
      bad_pattern <= bad_n;
      sel_err     <= sel_err_n;
    end
  end

endmodule

// File: tb/tb_sevenseg_rx_decoder.sv
// tb/tb_sevenseg_rx_decoder.sv - bench for sevenseg_rx_decoder against a run-length reference model
// Honours HEX_DECODE_EN in the reference decode table.
module tb_sevenseg_rx_decoder;

  localparam int ND = 6;
  localparam int SC = 3;
  localparam int OW = 4*ND + ND + 3;
`ifdef HEX_DECODE_EN
  localparam int NVAL = 16;
`else
  localparam int NVAL = 10;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              sample_en = 1'b0;
  logic [6:0]        seg_in = 7'h7F;
  logic [ND-1:0]     dig_sel = '0;
  logic [4*ND-1:0]   digits;
  logic [ND-1:0]     dvalid;
  logic              update;
  logic              bad_pattern;
  logic              sel_err;

  sevenseg_rx_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .seg_in(seg_in),
    .dig_sel(dig_sel), .digits(digits), .dvalid(dvalid), .update(update),
    .bad_pattern(bad_pattern), .sel_err(sel_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: per digit, last pattern seen and its unbounded run length.
  logic [6:0] m_last [ND];
  int         m_run  [ND];
  int         m_val  [ND];
  bit         m_dv   [ND];
  bit         e_upd, e_bad, e_sel;

  function automatic int lookup(input logic [6:0] p);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
            7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int i = 0; i < NVAL; i++) if (tab[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [OW-1:0] expected();
    logic [4*ND-1:0] d;
    logic [ND-1:0]   v;
    for (int i = 0; i < ND; i++) begin
      d[4*i +: 4] = 4'(m_val[i]);
      v[i]        = m_dv[i];
    end
    return {d, v, e_upd, e_bad, e_sel};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {digits, dvalid, update, bad_pattern, sel_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_last[i] = 7'h7F; m_run[i] = 0; m_val[i] = 0; m_dv[i] = 0;
    end
    e_upd = 0; e_bad = 0; e_sel = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_en = 1'b1; seg_in = 7'b0100100; dig_sel = ND'(1);
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b0; sample_en = 1'b0;
  endtask

  task automatic step(input bit en, input logic [6:0] seg, input logic [ND-1:0] sel);
    int idx;
    int v;
    sample_en = en; seg_in = seg; dig_sel = sel;
    @(posedge clock);
    e_upd = 0; e_bad = 0; e_sel = 0;
    if (en) begin
      if ($countones(sel) != 1) e_sel = 1;
      else begin
        idx = 0;
        for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
        if (seg == m_last[idx]) m_run[idx]++;
        else begin m_last[idx] = seg; m_run[idx] = 1; end
        if (m_run[idx] == SC) begin
          v = lookup(seg);
          if (v >= 0) begin
            e_upd = (m_val[idx] != v) || !m_dv[idx];
            m_val[idx] = v; m_dv[idx] = 1;
          end else begin
            e_upd = m_dv[idx]; m_dv[idx] = 0;
            e_bad = (seg != 7'h7F);
          end
        end
      end
    end
    @(negedge clock);
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (digits !== '0) begin errors++; $display("FAIL reset_digits: got %h expected 0", digits); end
    checks++; if (dvalid !== '0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", dvalid); end
    checks++; if ({update, bad_pattern, sel_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {update, bad_pattern, sel_err}); end
    checks++; if (observed() !== expected()) begin errors++; $display("FAIL reset_model: got %h expected %h", observed(), expected()); end
  endtask

  task automatic test_commit();
    for (int k = 0; k < 3; k++) begin
      step(1, 7'b0100100, 6'b000001);
      checks++; if (observed() !== expected()) begin errors++; $display("FAIL commit s%0d: got %h expected %h", k, observed(), expected()); end
    end
    checks++; if ({digits[3:0], dvalid[0], update} !== {4'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL commit_digit0: got %h/%b/%b expected 2/1/1", digits[3:0], dvalid[0], update); end
  endtask

  task automatic test_glitch();
    logic [6:0] seq [9];
    int ups;
    seq = '{7'b0011001, 7'b0011001, 7'b0010010, 7'b0011001, 7'b0011001, 7'b0011001,
            7'b0010010, 7'b0011001, 7'b0011001};
    ups = 0;
    for (int k = 0; k < 9; k++) begin
      step(1, seq[k], 6'b000010);
      ups += int'(update);
      checks++; if (observed() !== expected()) begin errors++; $display("FAIL glitch s%0d: got %h expected %h", k, observed(), expected()); end
    end
    step(1, 7'b0011001, 6'b000010);
    ups += int'(update);
    checks++; if (digits[7:4] !== 4'd4 || ups != 1) begin
      errors++; $display("FAIL glitch_single_update: got digit %0d updates %0d expected 4 and 1", digits[7:4], ups); end
  endtask

  task automatic test_sel_err();
    logic [ND-1:0] sels [3];
    sels = '{6'b000011, 6'b000000, 6'b110000};
    for (int k = 0; k < 3; k++) begin
      step(1, 7'b1111001, sels[k]);
      checks++; if (sel_err !== 1'b1 || observed() !== expected()) begin
        errors++; $display("FAIL sel_err s%0d: got %h expected %h", k, observed(), expected()); end
    end
    step(0, 7'b1111001, 6'b000011);
    checks++; if (observed() !== expected()) begin errors++; $display("FAIL sel_err_idle: got %h expected %h", observed(), expected()); end
  endtask

  task automatic test_bad_pattern();
    for (int k = 0; k < 3; k++) step(1, 7'b0110000, 6'b000100);
    for (int k = 0; k < 3; k++) begin
      step(1, 7'b1111110, 6'b000100);
      checks++; if (observed() !== expected()) begin errors++; $display("FAIL bad s%0d: got %h expected %h", k, observed(), expected()); end
    end
    checks++; if ({bad_pattern, dvalid[2], digits[11:8]} !== {1'b1, 1'b0, 4'd3}) begin
      errors++; $display("FAIL bad_keep: got %b/%b/%h expected 1/0/3", bad_pattern, dvalid[2], digits[11:8]); end
    for (int k = 0; k < 3; k++) begin
      step(1, 7'b0001000, 6'b000100);
      checks++; if (observed() !== expected()) begin errors++; $display("FAIL hex_a s%0d: got %h expected %h", k, observed(), expected()); end
    end
  endtask

  task automatic test_blank();
    for (int k = 0; k < 3; k++) step(1, 7'b1111000, 6'b001000);
    for (int k = 0; k < 3; k++) begin
      step(1, 7'b1111111, 6'b001000);
      checks++; if (observed() !== expected()) begin errors++; $display("FAIL blank s%0d: got %h expected %h", k, observed(), expected()); end
    end
    checks++; if ({dvalid[3], digits[15:12], update, bad_pattern} !== {1'b0, 4'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL blank_final: got %b/%h/%b/%b expected 0/7/1/0", dvalid[3], digits[15:12], update, bad_pattern); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) step(1, 7'b0000000, 6'b000001);
    do_reset();
    checks++; if (observed() !== '0) begin errors++; $display("FAIL reset_mid: got %h expected 0", observed()); end
    step(1, 7'b0000000, 6'b000001);
    checks++; if (dvalid[0] !== 1'b0 || update !== 1'b0) begin
      errors++; $display("FAIL reset_mid_partial: got dvalid0=%b update=%b expected 0/0", dvalid[0], update); end
    for (int k = 0; k < 2; k++) step(1, 7'b0000000, 6'b000001);
    checks++; if ({digits[3:0], dvalid[0], update} !== {4'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_mid_commit: got %h/%b/%b expected 8/1/1", digits[3:0], dvalid[0], update); end
  endtask

  task automatic test_random();
    logic [6:0] pool [8];
    logic [6:0] want [ND];
    logic [6:0] p;
    logic [ND-1:0] s;
    int d;
    pool = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0011001, 7'b1111000,
             7'b1111111, 7'b1111110, 7'b0001000};
    for (int i = 0; i < ND; i++) want[i] = pool[$urandom_range(7)];
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(199) == 0) do_reset();
      d = $urandom_range(ND-1);
      if ($urandom_range(9) == 0) want[d] = pool[$urandom_range(7)];
      p = ($urandom_range(7) == 0) ? pool[$urandom_range(7)] : want[d];
      s = ($urandom_range(9) == 0) ? ND'($urandom) : ND'(1) << d;
      step($urandom_range(4) != 0, p, s);
      checks++; if (observed() !== expected()) begin errors++; $display("FAIL random c%0d: got %h expected %h", k, observed(), expected()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit();
    test_glitch();
    test_sel_err();
    test_bad_pattern();
    test_blank();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
